// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared encodings for the multicycle RISC control unit: widths, FSM state
// codes, opcodes, mux-select encodings and the per-cycle control payload.
package multi_cycle_control_unit_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 16;

  // FSM state encodings; 101..111 are unused and fall back to FETCH
  localparam logic [ST_W-1:0] ST_FETCH   = 3'b000;
  localparam logic [ST_W-1:0] ST_DECODE  = 3'b001;
  localparam logic [ST_W-1:0] ST_EXECUTE = 3'b010;
  localparam logic [ST_W-1:0] ST_MEM     = 3'b011;
  localparam logic [ST_W-1:0] ST_WB      = 3'b100;

  // Opcodes (IR[15:12])
  localparam logic [OP_W-1:0] OP_AND     = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD     = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB     = 4'd2;
  localparam logic [OP_W-1:0] OP_ADDI    = 4'd3;
  localparam logic [OP_W-1:0] OP_ANDI    = 4'd4;
  localparam logic [OP_W-1:0] OP_LW      = 4'd5;
  localparam logic [OP_W-1:0] OP_LB      = 4'd6;
  localparam logic [OP_W-1:0] OP_SW      = 4'd7;
  localparam logic [OP_W-1:0] OP_BGT     = 4'd8;
  localparam logic [OP_W-1:0] OP_BLT     = 4'd9;
  localparam logic [OP_W-1:0] OP_BEQ     = 4'd10;
  localparam logic [OP_W-1:0] OP_BNE     = 4'd11;
  localparam logic [OP_W-1:0] OP_JMP     = 4'd12;
  localparam logic [OP_W-1:0] OP_CALL    = 4'd13;
  localparam logic [OP_W-1:0] OP_RET     = 4'd14;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'd15;

  // PC source select
  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_RET = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Per-cycle control word driven to the datapath
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       ra_write;
    logic       alu_src;
    logic       ext_signed;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       wb_sel;
    logic       l_type;
    logic       illegal;
  } ctrl_t;

  // Clear every state-changing strobe, keeping mux selects untouched
  function automatic ctrl_t strobes_off(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.ir_write  = 1'b0;
    r.pc_write  = 1'b0;
    r.reg_write = 1'b0;
    r.ra_write  = 1'b0;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    r.illegal   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and ALU flags in, strobes and
// selects out. Counter outputs exist only when PERF_CNT_EN is defined.
interface multi_cycle_control_unit_if;
  import multi_cycle_control_unit_pkg::*;

  logic [OP_W-1:0] op;
  logic            mode;
  logic            zero;
  logic            negative;
  logic            overflow;

  logic [ST_W-1:0] state;
  logic            ir_write;
  logic            pc_write;
  logic [1:0]      pc_src;
  logic            reg_write;
  logic            ra_write;
  logic            alu_src;
  logic            ext_signed;
  logic [1:0]      alu_op;
  logic            mem_read;
  logic            mem_write;
  logic            wb_sel;
  logic            l_type;
  logic            illegal;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
`endif

  // Control unit side
  modport master (
    input  op, mode, zero, negative, overflow,
    output state, ir_write, pc_write, pc_src, reg_write, ra_write,
           alu_src, ext_signed, alu_op, mem_read, mem_write, wb_sel,
           l_type, illegal
`ifdef PERF_CNT_EN
    , output instr_count, cycle_count
`endif
  );

  // Datapath side
  modport slave (
    output op, mode, zero, negative, overflow,
    input  state, ir_write, pc_write, pc_src, reg_write, ra_write,
           alu_src, ext_signed, alu_op, mem_read, mem_write, wb_sel,
           l_type, illegal
`ifdef PERF_CNT_EN
    , input instr_count, cycle_count
`endif
  );

endinterface

// File: rtl/multi_cycle_control_unit_branch_cond_eval.sv
// Branch condition evaluation from the flags of the SUB done in EXECUTE.
// cond_i is op[1:0]: 00 BGT, 01 BLT, 10 BEQ, 11 BNE.
module branch_cond_eval (
  input  logic [1:0] cond_i,
  input  logic       zero_i,
  input  logic       negative_i,
  input  logic       overflow_i,
  output logic       taken_o
);

  // Signed compare: less-than is N xor V, greater-than also excludes equality
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      2'b00:   taken_o = !zero_i && (negative_i == overflow_i);
      2'b01:   taken_o = negative_i != overflow_i;
      2'b10:   taken_o = zero_i;
      default: taken_o = !zero_i;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Main control FSM of the 16-bit multicycle RISC datapath.
// Optional retired-instruction / cycle counters behind macro PERF_CNT_EN.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multi_cycle_control_unit_if.master  bus
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  ctrl_t           ctrl_c;
  logic            taken_c;

  branch_cond_eval u_branch_cond_eval (
    .cond_i     (bus.op[1:0]),
    .zero_i     (bus.zero),
    .negative_i (bus.negative),
    .overflow_i (bus.overflow),
    .taken_o    (taken_c)
  );

  // State register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore control word; strobes masked while reset is low
  always_comb begin
    state_d = ST_FETCH;
    ctrl_c  = '0;
    case (state_q)
      ST_FETCH: begin
        state_d         = ST_DECODE;
        ctrl_c.ir_write = 1'b1;
        ctrl_c.pc_write = 1'b1;
        ctrl_c.pc_src   = PC_SRC_INC;
      end
      ST_DECODE: begin
        case (bus.op)
          OP_JMP: begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_JMP;
          end
          OP_CALL: begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_JMP;
            ctrl_c.ra_write = 1'b1;
          end
          OP_RET: begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_RET;
          end
          // PC already holds PC+1, so flagging is all an illegal op does
          OP_ILLEGAL: ctrl_c.illegal = 1'b1;
          default:    state_d = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        ctrl_c.alu_src    = (bus.op >= OP_ADDI) && (bus.op <= OP_SW);
        ctrl_c.ext_signed = (bus.op != OP_ANDI);
        case (bus.op)
          OP_AND, OP_ANDI:                     ctrl_c.alu_op = ALU_AND;
          OP_SUB, OP_BGT, OP_BLT, OP_BEQ,
          OP_BNE:                              ctrl_c.alu_op = ALU_SUB;
          default:                             ctrl_c.alu_op = ALU_ADD;
        endcase
        if (bus.op <= OP_ANDI) begin
          state_d = ST_WB;
        end else if (bus.op <= OP_SW) begin
          state_d = ST_MEM;
        end else if (bus.op <= OP_BNE) begin
          ctrl_c.pc_src   = PC_SRC_BR;
          ctrl_c.pc_write = taken_c;
        end
      end
      ST_MEM: begin
        ctrl_c.mem_read  = (bus.op == OP_LW) || (bus.op == OP_LB);
        ctrl_c.mem_write = (bus.op == OP_SW);
        if (bus.op == OP_LB) ctrl_c.l_type = bus.mode;
        if (ctrl_c.mem_read) state_d = ST_WB;
      end
      ST_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_sel    = (bus.op == OP_LW) || (bus.op == OP_LB);
      end
      default: ;
    endcase
    if (!reset) ctrl_c = strobes_off(ctrl_c);
  end

  assign bus.state      = state_q;
  assign bus.ir_write   = ctrl_c.ir_write;
  assign bus.pc_write   = ctrl_c.pc_write;
  assign bus.pc_src     = ctrl_c.pc_src;
  assign bus.reg_write  = ctrl_c.reg_write;
  assign bus.ra_write   = ctrl_c.ra_write;
  assign bus.alu_src    = ctrl_c.alu_src;
  assign bus.ext_signed = ctrl_c.ext_signed;
  assign bus.alu_op     = ctrl_c.alu_op;
  assign bus.mem_read   = ctrl_c.mem_read;
  assign bus.mem_write  = ctrl_c.mem_write;
  assign bus.wb_sel     = ctrl_c.wb_sel;
  assign bus.l_type     = ctrl_c.l_type;
  assign bus.illegal    = ctrl_c.illegal;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             retire_c;

  // An instruction retires on any entry into FETCH from another state
  assign retire_c = (state_q != ST_FETCH) && (state_d == ST_FETCH);

  // Free-running performance counters, wrapping, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (retire_c) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign bus.instr_count = instr_count_q;
  assign bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: the driver issues whole
// instructions (opcode plus ALU operands) and queues the expected per-cycle
// control word; a negedge monitor pops and compares.
module tb_multi_cycle_control_unit;
  import multi_cycle_control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_control_unit_if bus();

  multi_cycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       ra_write;
    logic       alu_src;
    logic       ext_signed;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       wb_sel;
    logic       l_type;
    logic       illegal;
`ifdef PERF_CNT_EN
    logic [15:0] instr_count;
    logic [15:0] cycle_count;
`endif
  } obs_t;

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  obs_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cyc;
  logic [15:0] exp_instr;

  function automatic obs_t sample_dut();
    obs_t o;
    o.state      = bus.state;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_src     = bus.pc_src;
    o.reg_write  = bus.reg_write;
    o.ra_write   = bus.ra_write;
    o.alu_src    = bus.alu_src;
    o.ext_signed = bus.ext_signed;
    o.alu_op     = bus.alu_op;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.wb_sel     = bus.wb_sel;
    o.l_type     = bus.l_type;
    o.illegal    = bus.illegal;
`ifdef PERF_CNT_EN
    o.instr_count = bus.instr_count;
    o.cycle_count = bus.cycle_count;
`endif
    return o;
  endfunction

  // Cycles per instruction class
  function automatic int num_phases(int op);
    if (op <= 4)  return 4;
    if (op <= 6)  return 5;
    if (op == 7)  return 4;
    if (op <= 11) return 3;
    return 2;
  endfunction

  // Which phase the k-th cycle of an instruction is in
  function automatic int phase_at(int op, int k);
    case (k)
      0: return PH_F;
      1: return PH_D;
      2: return PH_E;
      3: return (op >= 5 && op <= 7) ? PH_M : PH_W;
      default: return PH_W;
    endcase
  endfunction

  // Expected control word for one cycle, derived from the instruction meaning
  function automatic obs_t expect_phase(int ph, int op, bit mode, bit taken, bit in_reset);
    obs_t e;
    e       = '0;
    e.state = 3'(ph);
    case (ph)
      PH_F: begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      PH_D: begin
        if (op == 12 || op == 13) begin
          e.pc_write = 1'b1;
          e.pc_src   = 2'b10;
        end
        if (op == 13) e.ra_write = 1'b1;
        if (op == 14) begin
          e.pc_write = 1'b1;
          e.pc_src   = 2'b11;
        end
        if (op == 15) e.illegal = 1'b1;
      end
      PH_E: begin
        e.alu_src    = (op >= 3 && op <= 7);
        e.ext_signed = (op != 4);
        if (op == 0 || op == 4)                   e.alu_op = 2'b10;
        else if (op == 2 || (op >= 8 && op <= 11)) e.alu_op = 2'b01;
        if (op >= 8 && op <= 11) begin
          e.pc_src   = 2'b01;
          e.pc_write = taken;
        end
      end
      PH_M: begin
        e.mem_read  = (op == 5 || op == 6);
        e.mem_write = (op == 7);
        e.l_type    = (op == 6) ? mode : 1'b0;
      end
      default: begin
        e.reg_write = 1'b1;
        e.wb_sel    = (op == 5 || op == 6);
      end
    endcase
    if (in_reset) begin
      e.ir_write  = 1'b0;
      e.pc_write  = 1'b0;
      e.reg_write = 1'b0;
      e.ra_write  = 1'b0;
      e.mem_read  = 1'b0;
      e.mem_write = 1'b0;
      e.illegal   = 1'b0;
    end
    return e;
  endfunction

  // Issue one instruction whose EXECUTE compares a against b; abort_at >= 0
  // pulls reset low during that cycle of the instruction
  task automatic run_instr(int op, bit mode, logic [15:0] a, logic [15:0] b, int abort_at);
    logic [15:0] d;
    bit          taken;
    int          len;
    obs_t        e;
    d            = a - b;
    len          = num_phases(op);
    bus.op       = 4'(op);
    bus.mode     = mode;
    bus.zero     = (d == 16'h0000);
    bus.negative = d[15];
    bus.overflow = (a[15] != b[15]) && (d[15] != a[15]);
    case (op)
      8:       taken = $signed(a) >  $signed(b);
      9:       taken = $signed(a) <  $signed(b);
      10:      taken = a == b;
      11:      taken = a != b;
      default: taken = 1'b0;
    endcase
    for (int k = 0; k < len; k++) begin
      if (abort_at >= 0 && k > abort_at) break;
      e = expect_phase(phase_at(op, k), op, mode, taken, k == abort_at);
`ifdef PERF_CNT_EN
      e.cycle_count = exp_cyc + 16'(k);
      e.instr_count = exp_instr;
`endif
      sb.push_back(e);
    end
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk) #1;
      reset = 1'b0;
      @(posedge clk) #1;
      reset     = 1'b1;
      exp_cyc   = '0;
      exp_instr = '0;
    end else begin
      repeat (len) @(posedge clk) #1;
      exp_cyc   = exp_cyc + 16'(len);
      exp_instr = exp_instr + 16'd1;
    end
  endtask

  // Monitor: one expected word per cycle while the scoreboard has entries
  always @(negedge clk) begin
    obs_t got;
    obs_t exp_o;
    if (sb.size() != 0) begin
      exp_o = sb.pop_front();
      got   = sample_dut();
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL trace t=%0t state got=%0d exp=%0d word got=%h exp=%h",
                 $time, got.state, exp_o.state, got, exp_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        e;
    int          op;
    int          r;
    int          ab;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] edges [4];
    edges[0] = 16'h8000;
    edges[1] = 16'h7fff;
    edges[2] = 16'hffff;
    edges[3] = 16'h0000;

    reset        = 1'b0;
    bus.op       = '0;
    bus.mode     = 1'b0;
    bus.zero     = 1'b0;
    bus.negative = 1'b0;
    bus.overflow = 1'b0;
    exp_cyc      = '0;
    exp_instr    = '0;

    // Held in reset: FETCH with all strobes suppressed
    @(posedge clk) #1;
    n_tests++;
    if (bus.pc_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pc_write got=%b exp=0", bus.pc_write);
    end
    n_tests++;
    if (bus.ir_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ir_write got=%b exp=0", bus.ir_write);
    end
    n_tests++;
    if (bus.state !== ST_FETCH) begin
      n_fail++;
      $display("FAIL reset state got=%0d exp=%0d", bus.state, ST_FETCH);
    end
    for (int i = 0; i < 2; i++) begin
      e = expect_phase(PH_F, 0, 1'b0, 1'b0, 1'b1);
`ifdef PERF_CNT_EN
      e.cycle_count = 16'd0;
      e.instr_count = 16'd0;
`endif
      sb.push_back(e);
    end
    repeat (2) @(posedge clk) #1;
    reset = 1'b1;

    // Three back-to-back ADDs, then directed cases
    for (int i = 0; i < 3; i++) run_instr(1, 1'b0, 16'h1234, 16'h0042, -1);
    run_instr(6,  1'b1, 16'h0010, 16'h0003, -1);  // LB signed
    run_instr(10, 1'b0, 16'd5,    16'd5,    -1);  // BEQ taken
    run_instr(10, 1'b0, 16'd5,    16'd6,    -1);  // BEQ not taken
    run_instr(8,  1'b0, 16'h7fff, 16'hffff, -1);  // BGT taken, N=1 V=1
    run_instr(8,  1'b0, 16'h0001, 16'h0002, -1);  // BGT not taken, N=1 V=0
    run_instr(13, 1'b0, 16'h0000, 16'h0000, -1);  // CALL
    run_instr(15, 1'b0, 16'h0000, 16'h0000, -1);  // illegal
    run_instr(7,  1'b0, 16'h0020, 16'h0001, 3);   // SW aborted in MEM
    n_tests++;
    if (bus.state !== ST_FETCH) begin
      n_fail++;
      $display("FAIL abort state got=%0d exp=%0d", bus.state, ST_FETCH);
    end
    run_instr(1,  1'b0, 16'h0001, 16'h0001, -1);  // ADD right after abort

    // Randomized instruction stream with occasional aborts
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 15));
      a  = 16'($urandom);
      r  = int'($urandom_range(0, 3));
      if (r == 0)      b = a;
      else if (r == 1) b = edges[$urandom_range(0, 3)];
      else             b = 16'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, num_phases(op) - 1)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), a, b, ab);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Main control FSM for the 16-bit multicycle RISC datapath.
- Sits directly upstream of the datapath. Consumes the IR opcode/mode field and the ALU flags; produces every per-state strobe and mux select the datapath uses (PC write/source, IR write, register write, ALU controls, memory strobes, load type).
- Exports the 3-bit state so the bench can trace it.

Parameters:
- OP_W, 4, opcode width (instruction bits 15:12)
- ST_W, 3, state encoding width
- CNT_W, 16, performance counter width (used only with PERF_CNT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- op  in  4  IR[15:12]; valid from DECODE onward
- mode  in  1  IR[11]; load type for op 6 (0 = LBu, 1 = LBs)
- zero  in  1  ALU zero flag; combinational in EXECUTE
- negative  in  1  ALU sign flag
- overflow  in  1  ALU signed-overflow flag
- state  out  3  current FSM state
- ir_write  out  1  latch instruction memory into IR
- pc_write  out  1  load PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target, 11 = return register
- reg_write  out  1  register file write enable
- ra_write  out  1  write PC+1 into R7 (CALL)
- alu_src  out  1  0 = busB, 1 = sign/zero-extended immediate
- ext_signed  out  1  1 = sign-extend the 5-bit immediate
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = AND
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- l_type  out  1  byte-load sign select, equal to mode for op 6
- illegal  out  1  one-cycle pulse in DECODE for op 15
- instr_count, cycle_count  out  CNT_W  only with PERF_CNT_EN

Behaviour:
- Opcodes:
  - ALU: 0 AND, 1 ADD, 2 SUB, 3 ADDI, 4 ANDI
  - Memory: 5 LW, 6 LB(mode), 7 SW
  - Branch: 8 BGT, 9 BLT, 10 BEQ, 11 BNE
  - Jump: 12 JMP, 13 CALL, 14 RET
  - 15 illegal
- States: FETCH=000, DECODE=001, EXECUTE=010, MEM=011, WB=100. Codes 101–111 are unused and return to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE always.
  - DECODE -> FETCH for ops 12–15; otherwise -> EXECUTE.
  - EXECUTE -> MEM for ops 5–7; -> FETCH for ops 8–11; -> WB for ops 0–4.
  - MEM -> WB for ops 5–6; -> FETCH for op 7.
  - WB -> FETCH.
- Cycle counts per instruction: ALU = 4, LW/LB = 5, SW = 4, branch = 3, JMP/CALL/RET/illegal = 2.
- Outputs are Moore-style from the registered state plus the op input. Exception: the branch pc_write in EXECUTE also depends combinationally on the flags.
- Outputs by state:
  - FETCH: ir_write=1, pc_write=1, pc_src=00.
  - DECODE:
    - op 12: pc_write=1, pc_src=10.
    - op 13: pc_write=1, pc_src=10, ra_write=1.
    - op 14: pc_write=1, pc_src=11.
    - op 15: illegal=1, no PC write. PC is already PC+1, so execution continues.
  - EXECUTE:
    - alu_src=1 for ops 3–7.
    - ext_signed=0 for op 4 only.
    - alu_op=10 for ops 0 and 4; 01 for ops 2 and 8–11; else 00.
    - Branches: pc_src=01, pc_write = taken.
    - Taken conditions: BGT = !zero & (negative==overflow); BLT = negative!=overflow; BEQ = zero; BNE = !zero.
  - MEM: mem_read=1 for ops 5–6; mem_write=1 for op 7; l_type=mode for op 6.
  - WB: reg_write=1; wb_sel=1 for ops 5–6.
- All strobes not listed for a state are 0. Selects default to 0.
- Reset:
  - While reset==0 at a rising edge, state <= FETCH and counters clear.
  - All strobe outputs (ir_write, pc_write, reg_write, ra_write, mem_read, mem_write, illegal) are forced 0 combinationally while reset is low. This prevents a PC/IR update during reset.
  - Reset mid-instruction aborts it: no write strobe is issued in the reset cycle, and the next cycle is FETCH.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_count increments every non-reset cycle.
  - instr_count increments on every transition into FETCH from any state except FETCH (retired instruction).
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both counter ports and their logic are absent.

Decomposition:
- Shared package: state encodings, opcode constants, pc_src/alu_op encodings.
- One natural sub-module: branch_cond_eval, which takes op[1:0] and the flags and returns taken.

Test Plan:
- ADD (op=1) after reset release -> states 000,001,010,100,000; reg_write=1 only in WB with wb_sel=0; alu_op=00, alu_src=0 in EXECUTE.
- LB with mode=1 (op=6) -> 5 cycles; mem_read=1 and l_type=1 in MEM; wb_sel=1 and reg_write=1 in WB.
- BEQ (op=10): with zero=1, pc_write=1 and pc_src=01 in EXECUTE; with zero=0, pc_write=0; next state 000 in both cases.
- BGT (op=8): negative=1, overflow=1, zero=0 -> taken. negative=1, overflow=0 -> not taken.
- CALL (op=13) -> in DECODE pc_write=1, pc_src=10, ra_write=1; back in FETCH next cycle. Op 15 -> illegal pulses for one cycle; pc_write=0 in DECODE.
- Reset=0 asserted during MEM of SW -> mem_write=0 in that cycle; next state 000. With PERF_CNT_EN, three back-to-back ADDs give instr_count=3 and cycle_count=12.
